// File: rtl/alu_sequencer.sv
// One-request-at-a-time ALU for the grah-8 core: single-cycle logic/add/sub,
// iterative shift-add MUL and restoring DIV, valid/ready request and response channels.
module alu_sequencer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            instruction,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  req_disable,
    input  logic                  req_valid,
    output logic                  req_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic [DATA_WIDTH-1:0] result_hi,
    output logic                  carry,
    output logic                  zero,
    output logic                  div_by_zero,
    output logic                  illegal,
    output logic [10:0]           op_onehot,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  busy
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   work_hi_q, work_hi_d;
    logic [W-1:0]   work_lo_q, work_lo_d;
    logic [W-1:0]   opb_q, opb_d;
    logic [W-1:0]   result_q, result_d;
    logic [W-1:0]   result_hi_q, result_hi_d;
    logic           carry_q, carry_d;
    logic           zero_q, zero_d;
    logic           dbz_q, dbz_d;
    logic           illegal_q, illegal_d;
    logic [10:0]    op_onehot_q, op_onehot_d;

    logic [3:0]     opcode;
    logic [10:0]    dec_onehot;
    logic           accept;
    logic           long_op;
    logic [W:0]     sum_ext;
    logic [W:0]     diff_ext;
    logic [W-1:0]   simple_res;
    logic [W-1:0]   simple_hi;
    logic           simple_carry;
    logic           simple_dbz;
    logic           simple_illegal;
    logic [W:0]     mul_sum;
    logic [W-1:0]   mul_hi_next;
    logic [W-1:0]   mul_lo_next;
    logic [W:0]     div_shift;
    logic [W:0]     div_sub;
    logic           div_ge;
    logic [W-1:0]   div_rem_next;
    logic [W-1:0]   div_quo_next;
    logic           unused_upper_bits;

    assign opcode            = instruction[3:0];
    assign unused_upper_bits = ^instruction[7:4];

    assign req_ready   = (state_q == IDLE) & ~req_disable & ~rst;
    assign accept      = req_valid & req_ready;
    assign rsp_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign result      = result_q;
    assign result_hi   = result_hi_q;
    assign carry       = carry_q;
    assign zero        = zero_q;
    assign div_by_zero = dbz_q;
    assign illegal     = illegal_q;
    assign op_onehot   = op_onehot_q;

    // Only MUL and DIV with a nonzero divisor take the iterative path.
    assign long_op = (opcode == 4'd10) || ((opcode == 4'd11) && (b != '0));

    always_comb begin
        dec_onehot = '0;
        if ((opcode >= 4'd1) && (opcode <= 4'd11)) begin
            dec_onehot[opcode - 4'd1] = 1'b1;
        end
    end

    always_comb begin
        sum_ext        = {1'b0, a} + {1'b0, b};
        diff_ext       = {1'b0, a} - {1'b0, b};
        simple_res     = '0;
        simple_hi      = '0;
        simple_carry   = 1'b0;
        simple_dbz     = 1'b0;
        simple_illegal = 1'b0;
        case (opcode)
            4'd1: begin
                simple_res   = sum_ext[W-1:0];
                simple_carry = sum_ext[W];
            end
            4'd2: begin
                simple_res   = diff_ext[W-1:0];
                simple_carry = diff_ext[W];
            end
            4'd3: simple_res = ~a;
            4'd4: simple_res = a | b;
            4'd5: simple_res = ~(a | b);
            4'd6: simple_res = a ^ b;
            4'd7: simple_res = ~(a ^ b);
            4'd8: simple_res = a & b;
            4'd9: simple_res = ~(a & b);
            4'd11: begin
                simple_res = '1;
                simple_hi  = a;
                simple_dbz = 1'b1;
            end
            default: simple_illegal = 1'b1;
        endcase
    end

    // MUL keeps {hi, lo} as the partial product with the multiplier shifting out of lo;
    // DIV keeps the remainder in hi and the dividend/quotient shifting through lo.
    always_comb begin
        mul_sum      = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opb_q} : '0);
        mul_hi_next  = mul_sum[W:1];
        mul_lo_next  = {mul_sum[0], work_lo_q[W-1:1]};
        div_shift    = {work_hi_q, work_lo_q[W-1]};
        div_ge       = (div_shift >= {1'b0, opb_q});
        div_sub      = div_shift - {1'b0, opb_q};
        div_rem_next = div_ge ? div_sub[W-1:0] : div_shift[W-1:0];
        div_quo_next = {work_lo_q[W-2:0], div_ge};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_hi_d   = work_hi_q;
        work_lo_d   = work_lo_q;
        opb_d       = opb_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        dbz_d       = dbz_q;
        illegal_d   = illegal_q;
        op_onehot_d = op_onehot_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_onehot_d = dec_onehot;
                    opb_d       = b;
                    if (long_op) begin
                        state_d     = ITER;
                        cnt_d       = CW'(W);
                        work_hi_d   = '0;
                        work_lo_d   = a;
                        result_d    = '0;
                        result_hi_d = '0;
                        carry_d     = 1'b0;
                        zero_d      = 1'b0;
                        dbz_d       = 1'b0;
                        illegal_d   = 1'b0;
                    end else begin
                        state_d     = DONE;
                        result_d    = simple_res;
                        result_hi_d = simple_hi;
                        carry_d     = simple_carry;
                        zero_d      = (simple_res == '0);
                        dbz_d       = simple_dbz;
                        illegal_d   = simple_illegal;
                    end
                end
            end
            ITER: begin
                cnt_d = cnt_q - CW'(1);
                if (op_onehot_q[10]) begin
                    work_hi_d = div_rem_next;
                    work_lo_d = div_quo_next;
                end else begin
                    work_hi_d = mul_hi_next;
                    work_lo_d = mul_lo_next;
                end
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    if (op_onehot_q[10]) begin
                        result_d    = div_quo_next;
                        result_hi_d = div_rem_next;
                        carry_d     = 1'b0;
                        zero_d      = (div_quo_next == '0);
                    end else begin
                        result_d    = mul_lo_next;
                        result_hi_d = mul_hi_next;
                        carry_d     = (mul_hi_next != '0);
                        zero_d      = ({mul_hi_next, mul_lo_next} == '0);
                    end
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_hi_q   <= '0;
            work_lo_q   <= '0;
            opb_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            dbz_q       <= 1'b0;
            illegal_q   <= 1'b0;
            op_onehot_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_hi_q   <= work_hi_d;
            work_lo_q   <= work_lo_d;
            opb_q       <= opb_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            dbz_q       <= dbz_d;
            illegal_q   <= illegal_d;
            op_onehot_q <= op_onehot_d;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed cases plus random requests
// compared against an arithmetic reference model.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  instruction;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        req_disable;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  result;
    logic [7:0]  result_hi;
    logic        carry;
    logic        zero;
    logic        div_by_zero;
    logic        illegal;
    logic [10:0] op_onehot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        busy;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        int res;
        int hi;
        int carry;
        int zero;
        int dbz;
        int ill;
        int onehot;
        int lat;
    } exp_t;

    alu_sequencer #(.DATA_WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .a           (a),
        .b           (b),
        .req_disable (req_disable),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .result      (result),
        .result_hi   (result_hi),
        .carry       (carry),
        .zero        (zero),
        .div_by_zero (div_by_zero),
        .illegal     (illegal),
        .op_onehot   (op_onehot),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t refModel(int instr, int x, int y);
        exp_t e;
        int op;
        int full;
        op = instr % 16;
        e = '{0, 0, 0, 0, 0, 0, 0, 1};
        full = 0;
        case (op)
            1: begin full = x + y; e.res = full % 256; e.carry = (full > 255); end
            2: begin e.res = (x - y + 256) % 256; e.carry = (x < y); end
            3: e.res = 255 - x;
            4: e.res = x | y;
            5: e.res = 255 - (x | y);
            6: e.res = x ^ y;
            7: e.res = 255 - (x ^ y);
            8: e.res = x & y;
            9: e.res = 255 - (x & y);
            10: begin
                full = x * y;
                e.res = full % 256;
                e.hi = full / 256;
                e.carry = (e.hi != 0);
                e.lat = 9;
            end
            11: begin
                if (y == 0) begin
                    e.res = 255; e.hi = x; e.dbz = 1;
                end else begin
                    e.res = x / y; e.hi = x % y; e.lat = 9;
                end
            end
            default: e.ill = 1;
        endcase
        e.zero = (op == 10) ? (full == 0) : (e.res == 0);
        e.onehot = e.ill ? 0 : (1 << (op - 1));
        return e;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".result"}, int'(result), 0);
        checkOutput({tag, ".result_hi"}, int'(result_hi), 0);
        checkOutput({tag, ".flags"}, int'({carry, zero, div_by_zero, illegal}), 0);
        checkOutput({tag, ".op_onehot"}, int'(op_onehot), 0);
        checkOutput({tag, ".rsp_valid"}, int'(rsp_valid), 0);
        checkOutput({tag, ".busy"}, int'(busy), 0);
        checkOutput({tag, ".req_ready"}, int'(req_ready), 0);
    endtask

    task automatic checkResponse(input string tag, input exp_t e);
        checkOutput({tag, ".result"}, int'(result), e.res);
        checkOutput({tag, ".result_hi"}, int'(result_hi), e.hi);
        checkOutput({tag, ".carry"}, int'(carry), e.carry);
        checkOutput({tag, ".zero"}, int'(zero), e.zero);
        checkOutput({tag, ".div_by_zero"}, int'(div_by_zero), e.dbz);
        checkOutput({tag, ".illegal"}, int'(illegal), e.ill);
        checkOutput({tag, ".op_onehot"}, int'(op_onehot), e.onehot);
    endtask

    // Called one step after the accept edge; inputs are scrambled to prove latching.
    task automatic collectResponse(input string tag, input exp_t e, input int hold);
        int lat;
        instruction = 8'($urandom);
        a = 8'($urandom);
        b = 8'($urandom);
        checkOutput({tag, ".busy_after_accept"}, int'(busy), 1);
        checkOutput({tag, ".req_ready_busy"}, int'(req_ready), 0);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, ".latency"}, lat, e.lat);
        checkResponse(tag, e);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checkOutput({tag, ".hold_valid"}, int'(rsp_valid), 1);
            checkOutput({tag, ".hold_busy"}, int'(busy), 1);
            checkOutput({tag, ".hold_result"}, int'(result), e.res);
            checkOutput({tag, ".hold_carry"}, int'(carry), e.carry);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checkOutput({tag, ".released_valid"}, int'(rsp_valid), 0);
        checkOutput({tag, ".released_busy"}, int'(busy), 0);
    endtask

    task automatic applyStimulus(input string tag, input int instr, input int x, input int y,
                                 input int hold);
        int waited;
        exp_t e;
        e = refModel(instr, x, y);
        waited = 0;
        while (!req_ready && waited < 40) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput({tag, ".req_ready"}, int'(req_ready), 1);
        instruction = 8'(instr);
        a = 8'(x);
        b = 8'(y);
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        collectResponse(tag, e, hold);
    endtask

    initial begin
        int seen;
        int ri;
        int ra;
        int rb;
        rst = 1'b1;
        instruction = '0;
        a = '0;
        b = '0;
        req_disable = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst = 1'b0;
        #1;
        checkOutput("reset.req_ready_after", int'(req_ready), 1);

        applyStimulus("add_carry", 8'h01, 8'hF0, 8'h20, 3);
        applyStimulus("sub_borrow", 8'h02, 8'h05, 8'h07, 0);
        applyStimulus("nand_zero", 8'h09, 8'hFF, 8'hFF, 0);
        applyStimulus("mul_hi", 8'h0A, 8'hC8, 8'h03, 1);
        applyStimulus("mul_fit", 8'h0A, 8'h0F, 8'h11, 0);
        applyStimulus("mul_zero", 8'h0A, 8'h00, 8'h9B, 0);
        applyStimulus("div", 8'h0B, 200, 7, 0);
        applyStimulus("div_max", 8'h0B, 8'hFF, 8'h01, 0);
        applyStimulus("div_by_zero", 8'h0B, 8'h33, 8'h00, 2);
        applyStimulus("illegal_c", 8'h0C, 8'h12, 8'h34, 0);
        applyStimulus("illegal_0", 8'h00, 8'h12, 8'h34, 0);
        applyStimulus("upper_nibble", 8'hA1, 8'h10, 8'h22, 0);
        applyStimulus("not", 8'h03, 8'h5A, 8'h00, 0);

        // Reset four cycles into a multiply aborts it with no response.
        instruction = 8'h0A;
        a = 8'hC8;
        b = 8'h03;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkAllZero("mid_mul_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid || busy) seen++;
        end
        checkOutput("mid_mul_reset.no_response", seen, 0);

        req_disable = 1'b1;
        instruction = 8'h06;
        a = 8'h3C;
        b = 8'h55;
        req_valid = 1'b1;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (req_ready || busy) seen++;
        end
        checkOutput("disable.blocked", seen, 0);
        req_disable = 1'b0;
        #1;
        checkOutput("disable.ready_on_drop", int'(req_ready), 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        collectResponse("disable.xor", refModel(8'h06, 8'h3C, 8'h55), 0);

        for (int n = 0; n < 40; n++) begin
            ri = int'($urandom_range(0, 255));
            ra = int'($urandom_range(0, 255));
            rb = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            applyStimulus($sformatf("rand%0d_op%0d", n, ri % 16), ri, ra, rb,
                          int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
